odd_parity_frame_tx: RTL and testbench

Sequencing controller for the odd-parity datapath. It accepts a parallel word on a valid/ready handshake and serialises it as a framed line: start bit, data LSB first, odd-parity bit, stop bit. The parity is accumulated one bit at a time as the data shifts out. It sits between a parallel producer and a single-wire serial output, and owns all bit timing.

---
 rtl/odd_parity_frame_tx.sv | 133 +++++++++++++
 tb/tb_odd_parity_frame_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_frame_tx.sv
// odd_parity_frame_tx - serialises a parallel word as start, data LSB first, odd parity, stop.
// Owns all bit timing; tx_out is registered from the next-state view so it changes only on bit boundaries.
module odd_parity_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign in_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE);
  assign tx_out   = tx_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = START;
          shift_d = in_data;
          par_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line value is decided from the state being entered, so it lands with the bit boundary.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// tb/tb_odd_parity_frame_tx.sv - directed vector bench for odd_parity_frame_tx.
// Instance a: DATA_W=8, BIT_CYCLES=4; instance b: DATA_W=3, BIT_CYCLES=1.
module tb_odd_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in_valid;
  logic [7:0] a_in_data;
  logic       a_in_ready, a_tx_out, a_busy, a_done;
  logic       b_in_valid;
  logic [2:0] b_in_data;
  logic       b_in_ready, b_tx_out, b_busy, b_done;

  int n_vec = 0;
  int n_err = 0;

  odd_parity_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .tx_out(a_tx_out), .busy(a_busy), .done(a_done)
  );

  odd_parity_frame_tx #(.DATA_W(3), .BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .tx_out(b_tx_out), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    string      name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready_a(input string name);
    int t = 0;
    while (!a_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ready"}, 64'(a_in_ready), 64'd1);
  endtask

  // Called at the negedge of the first cycle after acceptance; returns at the done-cycle negedge.
  task automatic capture_a(input logic [7:0] d, input logic par, input string name, input int pulse_at);
    logic [43:0] got, exp;
    logic [10:0] seg;
    int busy_n = 0;
    int done_n = 0;
    int ones = 0;
    seg = {1'b1, par, d, 1'b0};
    for (int i = 0; i < 44; i++) begin
      exp[i] = seg[i / 4];
      got[i] = a_tx_out;
      if (a_busy) busy_n++;
      if (a_done) done_n++;
      if (i == pulse_at) begin
        a_in_valid = 1'b1;
        a_in_data  = 8'hFF;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int s = 1; s <= 9; s++) ones += int'(got[s * 4 + 1]);
    check({name, "_line"}, 64'(got), 64'(exp));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd44);
    check({name, "_done_early"}, 64'(done_n), 64'd0);
    check({name, "_ones_odd"}, 64'(ones % 2), 64'd1);
    check({name, "_done"}, 64'(a_done), 64'd1);
    check({name, "_done_busy"}, 64'(a_busy), 64'd0);
    check({name, "_done_ready"}, 64'(a_in_ready), 64'd1);
  endtask

  task automatic send_a(input logic [7:0] d, input logic par, input string name, input int pulse_at);
    wait_ready_a(name);
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    capture_a(d, par, name, pulse_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h00, 1'b1, "v00"};
    vecs[1] = '{8'h01, 1'b0, "v01"};
    vecs[2] = '{8'hA5, 1'b1, "vA5"};
    vecs[3] = '{8'h07, 1'b0, "v07"};
    vecs[4] = '{8'hFF, 1'b1, "vFF"};

    rst        = 1'b1;
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
    b_in_valid = 1'b0;
    b_in_data  = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(a_tx_out), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd0);
    check("rst_ready_b", 64'(b_in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 64'(a_in_ready), 64'd1);

    for (int v = 0; v < 5; v++) begin
      send_a(vecs[v].data, vecs[v].par, vecs[v].name, -1);
    end

    // Back-to-back with in_valid held high throughout
    wait_ready_a("b2b");
    a_in_valid = 1'b1;
    a_in_data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    capture_a(8'h3C, 1'b1, "b2b_first", -1);
    a_in_data = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    capture_a(8'hC3, 1'b1, "b2b_second", -1);

    // Word offered mid-DATA must be ignored
    send_a(8'h01, 1'b0, "busy_reject", 12);
    begin
      int busy_n = 0;
      int low_n = 0;
      for (int i = 0; i < 10; i++) begin
        if (a_busy) busy_n++;
        if (!a_tx_out) low_n++;
        @(negedge clk);
      end
      check("no_extra_busy", 64'(busy_n), 64'd0);
      check("no_extra_low", 64'(low_n), 64'd0);
    end

    // Reset during PARITY
    wait_ready_a("midrst");
    a_in_valid = 1'b1;
    a_in_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (37) @(negedge clk);
    check("midrst_parity_bit", 64'(a_tx_out), 64'd1);
    check("midrst_busy_before", 64'(a_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", 64'(a_tx_out), 64'd1);
    check("midrst_busy", 64'(a_busy), 64'd0);
    check("midrst_done", 64'(a_done), 64'd0);
    check("midrst_ready_in_rst", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", 64'(a_in_ready), 64'd1);
    send_a(8'h80, 1'b0, "after_rst_80", -1);

    // Narrow instance, one cycle per bit: sweep every value
    for (int v = 0; v < 8; v++) begin
      logic [2:0] d;
      logic [5:0] got, exp;
      int busy_n;
      d = 3'(v);
      busy_n = 0;
      exp = {1'b1, ~^d, d, 1'b0};
      check($sformatf("b%0d_ready", v), 64'(b_in_ready), 64'd1);
      b_in_valid = 1'b1;
      b_in_data  = d;
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
        got[i] = b_tx_out;
        if (b_busy) busy_n++;
        @(negedge clk);
      end
      check($sformatf("b%0d_line", v), 64'(got), 64'(exp));
      check($sformatf("b%0d_busy_cycles", v), 64'(busy_n), 64'd6);
      check($sformatf("b%0d_done", v), 64'(b_done), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
